// File: rtl/cmd_decoder.sv
// cmd_decoder: decodes ASCII command bytes into one-hot movement levels, holds the e-stop latch
// and echoes one ack byte per command. The link-loss watchdog is compiled in by `define CMD_WATCHDOG_EN.
module cmd_decoder #(
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   input  logic       tx_ready,
   output logic       fwd_out,
   output logic       bwd_out,
   output logic       left_out,
   output logic       right_out,
   output logic       stop_out,
   output logic       estop,
   output logic       timeout,
   output logic       ack_overrun
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 32;

   localparam logic [BYTE_W-1:0] CH_F        = 8'h46;
   localparam logic [BYTE_W-1:0] CH_B        = 8'h42;
   localparam logic [BYTE_W-1:0] CH_L        = 8'h4C;
   localparam logic [BYTE_W-1:0] CH_R        = 8'h52;
   localparam logic [BYTE_W-1:0] CH_S        = 8'h53;
   localparam logic [BYTE_W-1:0] CH_X        = 8'h58;
   localparam logic [BYTE_W-1:0] CH_C        = 8'h43;
   localparam logic [BYTE_W-1:0] ACK_ESTOP   = 8'h21;
   localparam logic [BYTE_W-1:0] ACK_UNKNOWN = 8'h3F;
   localparam logic [BYTE_W-1:0] LOWER_A     = 8'h61;
   localparam logic [BYTE_W-1:0] LOWER_Z     = 8'h7A;
   localparam logic [BYTE_W-1:0] CASE_OFFSET = 8'h20;

   typedef enum logic [2:0] {
      ST_STOP,
      ST_FWD,
      ST_BWD,
      ST_LEFT,
      ST_RIGHT
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              w_next_estop;
   logic [BYTE_W-1:0] w_upper;
   logic [BYTE_W-1:0] w_ack;
   logic              w_expire;

   // Fold lower-case letters onto upper case so decode is case-insensitive.
   always_comb begin
      w_upper = rx_data;
      if ((rx_data >= LOWER_A) && (rx_data <= LOWER_Z)) begin
         w_upper = rx_data - CASE_OFFSET;
      end
   end

   // Next command state, e-stop latch and ack byte; a received byte takes priority over expiry.
   always_comb begin
      w_next_state = r_state;
      w_next_estop = estop;
      w_ack        = rx_data;
      if (rx_valid) begin
         case (w_upper)
            CH_F: begin
               if (estop) w_ack = ACK_ESTOP;
               else       w_next_state = ST_FWD;
            end
            CH_B: begin
               if (estop) w_ack = ACK_ESTOP;
               else       w_next_state = ST_BWD;
            end
            CH_L: begin
               if (estop) w_ack = ACK_ESTOP;
               else       w_next_state = ST_LEFT;
            end
            CH_R: begin
               if (estop) w_ack = ACK_ESTOP;
               else       w_next_state = ST_RIGHT;
            end
            CH_S: begin
               w_next_state = ST_STOP;
            end
            CH_X: begin
               w_next_estop = 1'b1;
               w_next_state = ST_STOP;
            end
            CH_C: begin
               w_next_estop = 1'b0;
            end
            default: begin
               w_ack = ACK_UNKNOWN;
            end
         endcase
      end else if (w_expire) begin
         w_next_state = ST_STOP;
      end
      if (w_next_estop) begin
         w_next_state = ST_STOP;
      end
   end

`ifdef CMD_WATCHDOG_EN
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_wd_cnt;

   assign w_expire = !rx_valid && (r_state != ST_STOP) && (r_wd_cnt == WD_LAST);

   // Counts idle cycles spent moving; expiry clears it, so it never wraps.
   always_ff @(posedge clk) begin
      if (rst || rx_valid || (r_state == ST_STOP) || w_expire) begin
         r_wd_cnt <= '0;
      end else begin
         r_wd_cnt <= r_wd_cnt + CNT_W'(1);
      end
   end
`else
   logic w_unused_timeout_cfg;

   assign w_unused_timeout_cfg = ^(CNT_W'(TIMEOUT_CYCLES));
   assign w_expire             = 1'b0;
`endif

   // Command register, registered one-hot decode and the ack handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_STOP;
         fwd_out     <= 1'b0;
         bwd_out     <= 1'b0;
         left_out    <= 1'b0;
         right_out   <= 1'b0;
         stop_out    <= 1'b1;
         estop       <= 1'b0;
         timeout     <= 1'b0;
         tx_valid    <= 1'b0;
         tx_data     <= '0;
         ack_overrun <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         fwd_out   <= (w_next_state == ST_FWD);
         bwd_out   <= (w_next_state == ST_BWD);
         left_out  <= (w_next_state == ST_LEFT);
         right_out <= (w_next_state == ST_RIGHT);
         stop_out  <= (w_next_state == ST_STOP);
         estop     <= w_next_estop;
         timeout   <= w_expire;
         if (rx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= w_ack;
            if (tx_valid && !tx_ready) begin
               ack_overrun <= 1'b1;
            end
         end else if (tx_ready) begin
            tx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed plus randomized bench for cmd_decoder, checked against a character-level reference model.
`timescale 1ns/1ps
module tb_cmd_decoder;

   localparam int unsigned TO = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       tx_ready = 1'b0;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       fwd_out, bwd_out, left_out, right_out, stop_out;
   logic       estop, timeout, ack_overrun;

   always #5 clk = ~clk;

   cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .fwd_out(fwd_out), .bwd_out(bwd_out), .left_out(left_out),
      .right_out(right_out), .stop_out(stop_out), .estop(estop),
      .timeout(timeout), .ack_overrun(ack_overrun)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: movement state held as the command letter itself.
   byte unsigned m_state = 8'h53;
   bit           m_estop = 1'b0;
   bit           m_txv = 1'b0;
   byte unsigned m_txd = 8'h00;
   bit           m_ovr = 1'b0;
   bit           m_timeout = 1'b0;
   int           m_idle = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input bit rs, input bit rv, input byte unsigned rd, input bit tr);
      byte unsigned u;
      byte unsigned ack;
      if (rs) begin
         m_state = 8'h53; m_estop = 0; m_txv = 0; m_txd = 8'h00;
         m_ovr = 0; m_timeout = 0; m_idle = 0;
         return;
      end
      m_timeout = 0;
      if (rv) begin
         u = (rd >= 8'h61 && rd <= 8'h7A) ? rd - 8'h20 : rd;
         ack = rd;
         if (u == 8'h46 || u == 8'h42 || u == 8'h4C || u == 8'h52) begin
            if (m_estop) ack = 8'h21;
            else m_state = u;
         end else if (u == 8'h53) begin
            m_state = 8'h53;
         end else if (u == 8'h58) begin
            m_estop = 1; m_state = 8'h53;
         end else if (u == 8'h43) begin
            m_estop = 0;
         end else begin
            ack = 8'h3F;
         end
         if (m_txv && !tr) m_ovr = 1;
         m_txv = 1;
         m_txd = ack;
         m_idle = 0;
      end else begin
         if (m_txv && tr) m_txv = 0;
`ifdef CMD_WATCHDOG_EN
         if (m_state != 8'h53) begin
            m_idle++;
            if (m_idle == int'(TO)) begin
               m_state = 8'h53; m_timeout = 1; m_idle = 0;
            end
         end else begin
            m_idle = 0;
         end
`endif
      end
   endtask

   task automatic check_model();
      chk("fwd_out",     fwd_out,     8'(m_state == 8'h46));
      chk("bwd_out",     bwd_out,     8'(m_state == 8'h42));
      chk("left_out",    left_out,    8'(m_state == 8'h4C));
      chk("right_out",   right_out,   8'(m_state == 8'h52));
      chk("stop_out",    stop_out,    8'(m_state == 8'h53));
      chk("estop",       estop,       8'(m_estop));
      chk("tx_valid",    tx_valid,    8'(m_txv));
      chk("tx_data",     tx_data,     m_txd);
      chk("ack_overrun", ack_overrun, 8'(m_ovr));
      chk("timeout",     timeout,     8'(m_timeout));
   endtask

   task automatic cycle(input bit rs, input bit rv, input byte unsigned rd, input bit tr);
      rst = rs; rx_valid = rv; rx_data = rd; tx_ready = tr;
      @(posedge clk);
      model_step(rs, rv, rd, tr);
      #1;
      check_model();
   endtask

   initial begin
      byte unsigned cmds [7] = '{8'h46, 8'h42, 8'h4C, 8'h52, 8'h53, 8'h58, 8'h43};
      byte unsigned rd;
      bit saw_timeout;
      int k;

      // Reset
      cycle(1, 0, 8'h00, 0);
      cycle(1, 0, 8'h00, 0);
      chk("rst_stop", stop_out, 8'h01);
      chk("rst_txv", tx_valid, 8'h00);
      chk("rst_txd", tx_data, 8'h00);

      // 'F' then handshake
      cycle(0, 1, 8'h46, 0);
      chk("f_fwd", fwd_out, 8'h01);
      chk("f_stop", stop_out, 8'h00);
      chk("f_txd", tx_data, 8'h46);
      cycle(0, 0, 8'h00, 0);
      chk("f_hold_txv", tx_valid, 8'h01);
      cycle(0, 0, 8'h00, 1);
      chk("f_sent_txv", tx_valid, 8'h00);

      // lower case and unknown byte
      cycle(0, 1, 8'h66, 1);
      chk("lf_fwd", fwd_out, 8'h01);
      chk("lf_txd", tx_data, 8'h66);
      cycle(0, 1, 8'h51, 1);
      chk("q_fwd", fwd_out, 8'h01);
      chk("q_txd", tx_data, 8'h3F);

      // e-stop, blocked move, clear, move
      cycle(0, 1, 8'h58, 1);
      chk("x_estop", estop, 8'h01);
      chk("x_stop", stop_out, 8'h01);
      cycle(0, 1, 8'h52, 1);
      chk("xr_txd", tx_data, 8'h21);
      chk("xr_stop", stop_out, 8'h01);
      cycle(0, 1, 8'h43, 1);
      chk("c_estop", estop, 8'h00);
      chk("c_txd", tx_data, 8'h43);
      cycle(0, 1, 8'h52, 1);
      chk("r_right", right_out, 8'h01);

      // same-cycle transfer (no overrun), then overrun
      cycle(0, 1, 8'h4C, 1);
      chk("l_no_ovr", ack_overrun, 8'h00);
      cycle(0, 0, 8'h00, 0);
      cycle(0, 1, 8'h42, 0);
      chk("b_txd", tx_data, 8'h42);
      chk("b_ovr", ack_overrun, 8'h01);
      chk("b_bwd", bwd_out, 8'h01);

      // reset mid-operation ignores that cycle's byte
      cycle(1, 1, 8'h46, 1);
      chk("mrst_stop", stop_out, 8'h01);
      chk("mrst_ovr", ack_overrun, 8'h00);
      chk("mrst_txv", tx_valid, 8'h00);

`ifdef CMD_WATCHDOG_EN
      cycle(0, 1, 8'h46, 1);
      for (int i = 1; i < int'(TO); i++) cycle(0, 0, 8'h00, 1);
      chk("wd_pre_timeout", timeout, 8'h00);
      chk("wd_pre_fwd", fwd_out, 8'h01);
      cycle(0, 0, 8'h00, 1);
      chk("wd_timeout", timeout, 8'h01);
      chk("wd_stop", stop_out, 8'h01);
      cycle(0, 0, 8'h00, 1);
      chk("wd_pulse_end", timeout, 8'h00);
      cycle(0, 1, 8'h46, 1);
      for (int i = 1; i < int'(TO); i++) cycle(0, 0, 8'h00, 1);
      cycle(0, 1, 8'h46, 1);
      chk("wd_refresh_timeout", timeout, 8'h00);
      chk("wd_refresh_fwd", fwd_out, 8'h01);
`else
      cycle(0, 1, 8'h46, 1);
      saw_timeout = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         cycle(0, 0, 8'h00, 1);
         if (timeout !== 1'b0) saw_timeout = 1'b1;
      end
      chk("hold_fwd", fwd_out, 8'h01);
      chk("hold_no_timeout", 8'(saw_timeout), 8'h00);
`endif

      // Randomized traffic with occasional long idle stretches
      for (int i = 0; i < 3000; i++) begin
         if (i % 400 == 399) begin
            for (int j = 0; j < 130; j++) cycle(0, 0, 8'h00, 1'($urandom_range(0, 1)));
         end
         k = $urandom_range(0, 9);
         if (k < 7) rd = cmds[k] | (($urandom_range(0, 1) == 1) ? 8'h20 : 8'h00);
         else rd = 8'($urandom);
         cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), rd,
               1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cmd_decoder.md
# cmd_decoder

Byte-command front end for the rover motor path. Accepts ASCII command bytes from the UART receiver and decodes them into the one-hot movement level signals (forward/backward/left/right/stop) that feed the motor driver. It also holds an emergency-stop latch, echoes an acknowledge byte per command back to the UART transmitter, and optionally enforces a link-loss watchdog.

## Interface
- TIMEOUT_CYCLES, 50_000_000: watchdog period in clk cycles, 1 s at 50 MHz; legal range 2 to 2^32-1.
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_valid  out  1  acknowledge byte pending.
- tx_data  out  8  acknowledge byte, stable while tx_valid=1.
- tx_ready  in  1  UART transmitter accepts tx_data this cycle.
- fwd_out, bwd_out, left_out, right_out, stop_out  out  1 each  movement levels; exactly one high at all times.
- estop  out  1  emergency-stop latch state.
- timeout  out  1  one-cycle pulse on watchdog expiry.
- ack_overrun  out  1  sticky: an unsent ack was replaced.

## Operation
- Command register has 5 states: STOP, FWD, BWD, LEFT, RIGHT. The outputs are a one-hot decode of this register.
- Decode is case-insensitive. The ack byte is the received byte unless stated otherwise.
  - 'F' 0x46 / 'B' 0x42 / 'L' 0x4C / 'R' 0x52: go to FWD/BWD/LEFT/RIGHT. If estop=1, no state change and ack '!' 0x21.
  - 'S' 0x53: go to STOP (also while estop=1).
  - 'X' 0x58: set estop, go to STOP.
  - 'C' 0x43: clear estop, stay in STOP. If estop=0, ack the byte with no other effect.
  - Any other byte: no state change, ack '?' 0x3F.
- While estop=1, the register is forced to STOP and stop_out=1.
- Repeating the current command is legal. It re-acks and restarts the watchdog.
- Ack handshake:
  - An accepted byte loads tx_data and sets tx_valid.
  - tx_valid and tx_data are held until a cycle with tx_valid=1 and tx_ready=1; tx_valid clears after that edge.
  - A new rx_valid while an ack is pending and not transferred that cycle overwrites tx_data with the new ack, keeps tx_valid=1, and sets ack_overrun.
  - A new rx_valid in the same cycle as a transfer loads the new ack and keeps tx_valid=1, with no overrun.
- rx_valid is never back-pressured. Every strobe is decoded.
- Reset values: STOP (stop_out=1, others 0), estop=0, tx_valid=0, tx_data=0x00, timeout=0, ack_overrun=0, watchdog counter=0.

## Timing
- Latency: rx_valid sampled at edge N; movement outputs, estop and tx_valid/tx_data are valid after edge N (one cycle). All outputs are registered.
- Watchdog (when compiled in):
  - A 32-bit counter clears on any accepted byte and while the state is STOP.
  - In FWD/BWD/LEFT/RIGHT it increments each cycle.
  - On the cycle the count equals TIMEOUT_CYCLES-1, the next edge forces STOP, pulses timeout for one cycle, and clears the counter. There is no ack for a timeout.
  - The expiry cycle coincides with rx_valid: the received byte wins, the counter clears, and there is no timeout pulse.
  - The counter saturates logically: it never wraps, because expiry clears it.
- rst asserted mid-operation: all outputs take their reset values on the next edge, a pending ack is dropped, and the rx_valid of that cycle is ignored.

## Configuration
- CMD_WATCHDOG_EN defined: the watchdog is implemented as above.
- CMD_WATCHDOG_EN undefined: no counter is synthesized, timeout is tied 0, and movement commands hold indefinitely. TIMEOUT_CYCLES is ignored.

## Test plan
- Reset, then rx 'F' (0x46): fwd_out=1 one cycle later, stop_out=0; tx_valid=1 with tx_data=0x46, which clears after tx_ready=1.
- rx 'f' then 'Q': fwd_out=1 after 'f'; after 'Q' the state is still FWD and tx_data=0x3F.
- rx 'X', then 'R': estop=1, stop_out=1; 'R' acks 0x21 and the state stays STOP. Then 'C' (estop=0, ack 0x43), then 'R': right_out=1.
- With tx_ready=0, rx 'L' then 'B' two cycles apart: tx_data=0x42, ack_overrun=1, bwd_out=1.
- CMD_WATCHDOG_EN, TIMEOUT_CYCLES=100: after 'F' with no further bytes, stop_out=1 and timeout pulses exactly 100 cycles after the FWD state is entered. A 'F' resent at cycle 99 prevents the pulse.
- Without CMD_WATCHDOG_EN: after 'F', fwd_out stays 1 for 10,000 cycles and timeout stays 0.
